// File: rtl/axis_compute_fifo_if.sv
`default_nettype none
// ============================================================================
// Module : axis_compute_fifo_if
// Brief  : One AXI-Stream channel (data, keep, last, valid/ready handshake).
// Rev    : 1.0  initial release
// ============================================================================
interface axis_compute_fifo_if #(
  parameter int TDATA_WIDTH = 64,
  parameter int TDATA_BYTES = 8
);
  logic [TDATA_WIDTH-1:0] tdata;
  logic [TDATA_BYTES-1:0] tkeep;
  logic                   tlast;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_compute_fifo.sv
`default_nettype none
// ============================================================================
// Module : axis_compute_fifo
// Brief  : Byte-masked, mode-selected transform feeding a first-word-fall-through
//          FIFO, with a completed-output-packet counter.
// Rev    : 1.0  initial release
// ============================================================================
module axis_compute_fifo #(
  parameter int TDATA_WIDTH = 64,
  parameter int TDATA_BYTES = 8,
  parameter int DEPTH       = 16,
  parameter int LW          = $clog2(DEPTH) + 1
) (
  input  logic                s_axis_aclk,
  input  logic                s_axis_aresetn,
  output logic                m_axis_aclk,
  output logic                m_axis_aresetn,
  axis_compute_fifo_if.slave  s_axis,
  axis_compute_fifo_if.master m_axis,
  input  logic [1:0]          mode,
  output logic [LW-1:0]       fifo_level,
  output logic [15:0]         pkt_count,
  output logic [3:0]          leds_4bits_tri_o
);

  localparam int             HALF       = TDATA_WIDTH / 2;
  localparam int             PTR_W      = $clog2(DEPTH);
  localparam logic [LW-1:0]  FULL_LEVEL = LW'(DEPTH);

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_ADD  = 2'd1;
  localparam logic [1:0] MODE_XOR  = 2'd2;

  logic [TDATA_WIDTH-1:0] kept;
  logic [TDATA_WIDTH-1:0] xformed;
  logic [TDATA_WIDTH:0]   mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic                   wr_en;
  logic                   rd_en;

  assign m_axis_aclk      = s_axis_aclk;
  assign m_axis_aresetn   = s_axis_aresetn;
  assign leds_4bits_tri_o = pkt_count[3:0];

  // tready looks only at the registered level, never at the downstream ready.
  assign s_axis.tready = s_axis_aresetn && (fifo_level != FULL_LEVEL);
  assign m_axis.tvalid = (fifo_level != '0);
  assign m_axis.tkeep  = '1;
  assign {m_axis.tlast, m_axis.tdata} = mem[rd_ptr];

  assign wr_en = s_axis.tvalid && s_axis.tready;
  assign rd_en = m_axis.tvalid && m_axis.tready;

  always_comb begin
    kept = '0;
    for (int i = 0; i < TDATA_BYTES; i++) begin
      if (s_axis.tkeep[i]) kept[8*i +: 8] = s_axis.tdata[8*i +: 8];
    end
  end

  always_comb begin
    xformed = '0;
    case (mode)
      MODE_PASS: xformed = kept;
      MODE_ADD:  xformed[HALF:0] = {1'b0, kept[TDATA_WIDTH-1:HALF]} + {1'b0, kept[HALF-1:0]};
      MODE_XOR:  xformed[HALF-1:0] = kept[TDATA_WIDTH-1:HALF] ^ kept[HALF-1:0];
      default: begin
        for (int i = 0; i < TDATA_BYTES; i++) begin
          xformed[8*i +: 8] = kept[8*(TDATA_BYTES-1-i) +: 8];
        end
      end
    endcase
  end

  // Storage carries no reset; the level counter alone decides what is valid.
  always_ff @(posedge s_axis_aclk) begin
    if (wr_en) mem[wr_ptr] <= {s_axis.tlast, xformed};
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      pkt_count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (rd_en && m_axis.tlast) pkt_count <= pkt_count + 16'd1;
    end
  end

endmodule
`default_nettype wire
